// File: rtl/parallel_counter.sv
// ============================================================================
// Module   : parallel_counter
// Brief    : Two lock-step modulo-LIMIT counters, one up and one down, whose
//            sum is always LIMIT-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parallel_counter #(
    parameter int LIMIT = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] counter1,
    output logic [WIDTH-1:0] counter2
);

    generate
        if (LIMIT < 2 || LIMIT > (1 << WIDTH)) begin : g_limit_check
            $error("parallel_counter: LIMIT must satisfy 2 <= LIMIT <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_TOP  = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    // Declaration initialisers match the reset values so outputs are
    // defined from power-up even if rst is never asserted.
    logic [WIDTH-1:0] counter1_q = c_ZERO;
    logic [WIDTH-1:0] counter2_q = c_TOP;
    logic [WIDTH-1:0] counter1_d;
    logic [WIDTH-1:0] counter2_d;

    // Wrap is explicit so non-power-of-two moduli behave correctly.
    always_comb begin
        counter1_d = counter1_q + c_ONE;
        counter2_d = counter2_q - c_ONE;
        if (counter1_q == c_TOP) begin
            counter1_d = c_ZERO;
        end
        if (counter2_q == c_ZERO) begin
            counter2_d = c_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter1_q <= c_ZERO;
            counter2_q <= c_TOP;
        end else begin
            counter1_q <= counter1_d;
            counter2_q <= counter2_d;
        end
    end

    assign counter1 = counter1_q;
    assign counter2 = counter2_q;

endmodule

`default_nettype wire

// File: tb/tb_parallel_counter.sv
// ============================================================================
// Module   : tb_parallel_counter
// Brief    : Scoreboard bench for parallel_counter at LIMIT=8 and LIMIT=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parallel_counter;

    typedef struct {
        logic [3:0] c1_8;
        logic [3:0] c1_16;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] cnt1_8;
    logic [3:0] cnt2_8;
    logic [3:0] cnt1_16;
    logic [3:0] cnt2_16;

    exp_t q_exp[$];
    int   total;
    int   bad;

    parallel_counter #(.LIMIT(8), .WIDTH(4)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .counter1 (cnt1_8),
        .counter2 (cnt2_8)
    );

    parallel_counter #(.LIMIT(16), .WIDTH(4)) u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .counter1 (cnt1_16),
        .counter2 (cnt2_16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Expectation describes the outputs after the next rising edge.
    task automatic push(input int e8, input int e16, input string tag);
        exp_t e;
        e.c1_8  = 4'(e8);
        e.c1_16 = 4'(e16);
        e.tag   = tag;
        q_exp.push_back(e);
    endtask

    task automatic step(input logic r, input int e8, input int e16, input string tag);
        @(negedge clk);
        rst = r;
        push(e8, e16, tag);
    endtask

    // Monitor: one sample per cycle, well away from the rising edge.
    initial begin
        exp_t e;
        logic [4:0] sum8;
        forever begin
            @(negedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check4({e.tag, "/c1_L8"},  cnt1_8,  e.c1_8);
                check4({e.tag, "/c2_L8"},  cnt2_8,  4'd7 - e.c1_8);
                check4({e.tag, "/c1_L16"}, cnt1_16, e.c1_16);
                check4({e.tag, "/c2_L16"}, cnt2_16, 4'd15 - e.c1_16);
                sum8 = {1'b0, cnt1_8} + {1'b0, cnt2_8};
                check4({e.tag, "/sum_L8"}, sum8[3:0], 4'd7);
            end
        end
    end

    initial begin
        int e8;
        int e16;
        logic r;
        total = 0;
        bad   = 0;

        // Power-up with rst low from time 0: first edge at t=5.
        rst = 1'b0;
        push(1, 1, "pwrup");
        step(1'b0, 2, 2, "pwrup");
        step(1'b0, 3, 3, "pwrup");
        step(1'b0, 4, 4, "pwrup");
        step(1'b0, 5, 5, "pwrup");

        // Two reset edges, then release and run 32 edges through both wraps.
        step(1'b1, 0, 0, "rst");
        step(1'b1, 0, 0, "rst");
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, i % 8, i % 16, "wrap");
        end

        // Mid-run reset at counter1=5 / counter2=2.
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, i, i, "mid");
        end
        step(1'b1, 0, 0, "midrst");
        step(1'b0, 1, 1, "midrel");

        // Random reset pulses with the invariant checked every cycle.
        e8  = 1;
        e16 = 1;
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 9) == 0);
            if (r) begin
                e8  = 0;
                e16 = 0;
            end else begin
                e8  = (e8 + 1) % 8;
                e16 = (e16 + 1) % 16;
            end
            step(r, e8, e16, "rand");
        end

        @(negedge clk);
        #2;
        total++;
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d pending required=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
